// File: rtl/fexp2_bf16.sv
// fexp2_bf16: bfloat16 y = 2^x. The operand is split into integer n and fraction f, 2^f comes
// from a shift-add antilog recurrence, and the result packs n+BIAS over the rounded mantissa.
module fexp2_bf16 #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRACT_WIDTH = 7,
    parameter int BIAS        = 127,
    parameter int ITER        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sign,
    input  logic [EXP_WIDTH-1:0]   exponent,
    input  logic [FRACT_WIDTH-1:0] fractional,
    input  logic                   valid_i,
    output logic                   s_res_o,
    output logic [EXP_WIDTH-1:0]   e_res_o,
    output logic [FRACT_WIDTH-1:0] f_res_o,
    output logic                   valid_o,
    output logic                   busy_o
);

    // Handshake: valid_i is taken only while busy_o is low (IDLE); anything offered while busy
    // is dropped. valid_o is a single-cycle pulse, and s/e/f_res_o hold until the next result.

    localparam int RES_W  = 1 + EXP_WIDTH + FRACT_WIDTH;
    localparam int INT_W  = 8;
    localparam int MAG_W  = INT_W + ITER;
    localparam int FX_W   = MAG_W + 1;
    localparam int N_W    = INT_W + 1;
    localparam int SH_OFF = ITER - FRACT_WIDTH;
    localparam int SH_W   = $clog2(ITER);
    localparam int STEP_W = $clog2(ITER + 1);
    localparam int E_SAT  = 7;
    localparam int E_MAX  = (1 << EXP_WIDTH) - 1;

    localparam logic [RES_W-1:0] RES_ZERO = '0;
    localparam logic [RES_W-1:0] RES_ONE  = {1'b0, EXP_WIDTH'(BIAS), FRACT_WIDTH'(0)};
    localparam logic [RES_W-1:0] RES_INF  = {1'b0, {EXP_WIDTH{1'b1}}, FRACT_WIDTH'(0)};
    localparam logic [RES_W-1:0] RES_NAN  = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, (FRACT_WIDTH-1)'(0)};
    localparam logic [ITER:0]    ACC_ONE  = {1'b1, ITER'(0)};

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        ITERATE,
        PACK
    } state_t;

    state_t                 state;
    logic                   op_sign;
    logic [EXP_WIDTH-1:0]   op_exp;
    logic [FRACT_WIDTH-1:0] op_frac;
    logic                   special_q;
    logic [RES_W-1:0]       spec_res_q;
    logic [N_W-1:0]         n_q;
    logic [ITER-1:0]        r_q;
    logic [ITER:0]          acc_q;
    logic [STEP_W-1:0]      step_q;

    // T[i] = round(log2(1 + 2^-i) * 2^16)
    function automatic logic [ITER-1:0] t_val(input logic [STEP_W-1:0] i);
        case (i)
            5'd1:    t_val = 16'd38336;
            5'd2:    t_val = 16'd21098;
            5'd3:    t_val = 16'd11136;
            5'd4:    t_val = 16'd5732;
            5'd5:    t_val = 16'd2909;
            5'd6:    t_val = 16'd1466;
            5'd7:    t_val = 16'd736;
            5'd8:    t_val = 16'd369;
            5'd9:    t_val = 16'd184;
            5'd10:   t_val = 16'd92;
            5'd11:   t_val = 16'd46;
            5'd12:   t_val = 16'd23;
            5'd13:   t_val = 16'd12;
            5'd14:   t_val = 16'd6;
            5'd15:   t_val = 16'd3;
            5'd16:   t_val = 16'd1;
            default: t_val = '0;
        endcase
    endfunction

    int               e_unb;
    logic [SH_W-1:0]  sh;
    logic [MAG_W-1:0] mag;
    logic [FX_W-1:0]  fx;
    logic             conv_special;
    logic [RES_W-1:0] conv_res;

    // Operand to Q8.16 two's complement; exact whenever no special case applies.
    always_comb begin
        e_unb        = int'(op_exp) - BIAS;
        sh           = SH_W'(e_unb + SH_OFF);
        mag          = MAG_W'({1'b1, op_frac}) << sh;
        fx           = op_sign ? (FX_W'(0) - {1'b0, mag}) : {1'b0, mag};
        conv_special = 1'b1;
        conv_res     = RES_ONE;
        if (op_exp == '0) begin
            conv_res = RES_ONE;
        end else if (op_exp == '1) begin
            if (op_frac != '0) begin
                conv_res = RES_NAN;
            end else begin
                conv_res = op_sign ? RES_ZERO : RES_INF;
            end
        end else if (e_unb >= E_SAT) begin
            conv_res = op_sign ? RES_ZERO : RES_INF;
        end else if (e_unb < -SH_OFF) begin
            conv_res = RES_ONE;
        end else begin
            conv_special = 1'b0;
        end
    end

    logic [ITER-1:0] t_cur;

    always_comb begin
        t_cur = t_val(step_q);
    end

    logic [FRACT_WIDTH:0]   mant_sum;
    logic                   carry;
    logic [FRACT_WIDTH-1:0] mant;
    int                     e_pack;
    logic [RES_W-1:0]       pack_res;

    // Round half-up on the first dropped bit; a carry-out bumps the exponent.
    always_comb begin
        mant_sum = {1'b0, acc_q[ITER-1 -: FRACT_WIDTH]}
                 + {{FRACT_WIDTH{1'b0}}, acc_q[ITER-1-FRACT_WIDTH]};
        carry    = mant_sum[FRACT_WIDTH];
        mant     = carry ? '0 : mant_sum[FRACT_WIDTH-1:0];
        e_pack   = int'($signed(n_q)) + BIAS + int'(carry);
        if (e_pack <= 0) begin
            pack_res = RES_ZERO;
        end else if (e_pack >= E_MAX) begin
            pack_res = RES_INF;
        end else begin
            pack_res = {1'b0, EXP_WIDTH'(e_pack), mant};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_sign    <= 1'b0;
            op_exp     <= '0;
            op_frac    <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            n_q        <= '0;
            r_q        <= '0;
            acc_q      <= '0;
            step_q     <= '0;
            s_res_o    <= 1'b0;
            e_res_o    <= '0;
            f_res_o    <= '0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        op_sign <= sign;
                        op_exp  <= exponent;
                        op_frac <= fractional;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    special_q  <= conv_special;
                    spec_res_q <= conv_res;
                    n_q        <= fx[FX_W-1:ITER];
                    r_q        <= fx[ITER-1:0];
                    acc_q      <= ACC_ONE;
                    step_q     <= STEP_W'(1);
                    state      <= conv_special ? PACK : ITERATE;
                end
                ITERATE: begin
                    if (r_q >= t_cur) begin
                        r_q   <= r_q - t_cur;
                        acc_q <= acc_q + (acc_q >> step_q);
                    end
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == STEP_W'(ITER)) begin
                        state <= PACK;
                    end
                end
                PACK: begin
                    {s_res_o, e_res_o, f_res_o} <= special_q ? spec_res_q : pack_res;
                    valid_o <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: doc/fexp2_bf16.md
# fexp2_bf16

- Computes the base-2 exponential y = 2^x of a bfloat16 operand (1 sign, 8 exponent, 7 fraction bits, bias 127).
- Inverse companion of the flog datapath:
  - splits x into a signed integer part n and a fraction f in [0,1);
  - evaluates 2^f with a 16-step shift-add antilog recurrence;
  - packs n+127 as the result exponent and 2^f−1 as the mantissa.
- Single operand in flight. valid-in/valid-out handshake, with busy_o as back-pressure.

## Interface
- EXP_WIDTH, 8, exponent field width
- FRACT_WIDTH, 7, fraction field width
- BIAS, 127, exponent bias
- ITER, 16, recurrence steps; also the fixed-point fraction width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sign  in  1  operand sign
- exponent  in  EXP_WIDTH  operand biased exponent
- fractional  in  FRACT_WIDTH  operand fraction (hidden 1 implied)
- valid_i  in  1  operand valid; sampled only in IDLE
- s_res_o  out  1  result sign (always 0)
- e_res_o  out  EXP_WIDTH  result biased exponent
- f_res_o  out  FRACT_WIDTH  result fraction
- valid_o  out  1  one-cycle pulse, result valid
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- **States and transitions:**
  - IDLE→CONVERT on valid_i; operand registered.
  - CONVERT→ITERATE for normal operands, →PACK for special operands.
  - ITERATE→PACK after ITER steps.
  - PACK→IDLE.
- **Special cases, decided in CONVERT with the result preset:**
  - exponent==0 (zero or subnormal, treated as zero) → 1.0 = 0x3F80.
  - exponent==255 with fraction≠0 → canonical NaN 0x7FC0.
  - +inf → 0x7F80.
  - −inf → 0x0000.
  - Unbiased e=exponent−127 ≥ 7: positive → 0x7F80, negative → 0x0000.
  - e ≤ −10 → 0x3F80.
- **Fixed-point conversion (CONVERT):**
  - mag = {1,fractional} << (e+9), 24-bit Q8.16. Exact for e in [−9,6].
  - sign=1 → fx = −mag in 25-bit two's complement.
  - n = fx[24:16] (signed floor). f = fx[15:0] (unsigned Q0.16).
- **Recurrence (ITERATE):**
  - Initialise r=f, acc=1.0 in Q1.16 (17 bits).
  - Step i=1..16: if r ≥ T[i] then r −= T[i] and acc += acc>>i (truncating shift); otherwise both are unchanged.
  - T[i] = round(log2(1+2^−i)·2^16), held in a constant table.
- **Pack (PACK):**
  - mant = acc[15:9] + acc[8] (round half-up).
  - Mantissa carry-out → mant=0 and n+1.
  - E = n+127. E ≤ 0 → 0x0000 (flush, no subnormals). E ≥ 255 → 0x7F80. Otherwise {0,E[7:0],mant}.
- **Accuracy:** ≤1 ulp versus correctly rounded 2^x. Integer x gives an exact power of two.

## Timing
- valid_i is sampled at edge 0 in IDLE.
- Normal operand:
  - CONVERT registers at edge 1.
  - Iterations run at edges 2..17.
  - PACK registers the outputs at edge 18.
  - valid_o is high for the single cycle after edge 18. Latency is 18 cycles.
- Special operand: outputs register at edge 2. Latency is 2 cycles.
- State returns to IDLE at the same edge that raises valid_o. The next valid_i is accepted at the following edge, so throughput is 1 per 19 cycles.
- valid_i while busy_o=1 is ignored: the operand is dropped, with no queueing.
- s_res_o/e_res_o/f_res_o hold their value until the next PACK.
- **Reset (applies at any point, including mid-iteration):**
  - All outputs go to 0; busy_o=0; state→IDLE.
  - Internal registers are cleared.
  - No valid_o is produced for the aborted operand.

## Test plan
- Basic values, valid_i pulse each:
  - 0x3F80 (1.0) → 0x4000 after 18 cycles.
  - 0x0000 → 0x3F80 after 2 cycles.
  - 0x4120 (10.0) → 0x4480.
  - 0x4040 → 0x4100.
- Fractional and negative:
  - 0x3F00 (0.5) → 0x3FB5.
  - 0xBF00 (−0.5) → 0x3F35.
  - 0xBF80 (−1.0) → 0x3F00.
- Saturation and specials:
  - 0x4300 (128) → 0x7F80.
  - 0xC348 (−200) → 0x0000.
  - 0x42FE (127) → 0x7F00.
  - 0x7FC1 → 0x7FC0.
  - 0xFF80 → 0x0000.
- Handshake:
  - Assert valid_i with 0x4040 continuously.
  - Exactly one valid_o per 19 cycles.
  - busy_o high for 18 cycles after each acceptance.
  - Operands presented while busy produce no result.
- Reset mid-operation:
  - Start 0x3F00, assert rst at iteration 8.
  - No valid_o; outputs and busy_o are 0.
  - Next operand 0x3F80 → 0x4000 at normal latency.
- Sweep all 65536 encodings against a reference model of 2^x:
  - Specials and flushes match exactly.
  - Normal results are within 1 ulp.
